// File: rtl/wb_shared_bus_if.sv
// Bus bundle for wb_shared_bus.
// The 'slave' modport is the interconnect's face toward the bus masters
// (it is their slave). The 'master' modport is its face toward the slaves.
// One instance may be bound to both ports of the interconnect.
interface wb_shared_bus_if #(
  parameter int NM = 4,
  parameter int NS = 4,
  parameter int AW = 36,
  parameter int DW = 32
);
  // Master side: packed per master, master k at [k*W +: W]
  logic [NM-1:0]      m_cyc_i;
  logic [NM-1:0]      m_stb_i;
  logic [NM-1:0]      m_we_i;
  logic [NM*AW-1:0]   m_adr_i;
  logic [NM*DW/8-1:0] m_sel_i;
  logic [NM*DW-1:0]   m_dat_i;
  logic [DW-1:0]      m_dat_o;
  logic [NM-1:0]      m_ack_o;
  logic [NM-1:0]      m_err_o;

  // Slave side: one-hot cycle/strobe, shared request fields
  logic [NS-1:0]      s_cyc_o;
  logic [NS-1:0]      s_stb_o;
  logic               s_we_o;
  logic [AW-1:0]      s_adr_o;
  logic [DW/8-1:0]    s_sel_o;
  logic [DW-1:0]      s_dat_o;
  logic [NS*DW-1:0]   s_dat_i;
  logic [NS-1:0]      s_ack_i;
  logic [NS-1:0]      s_err_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o
  );

  modport master (
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_shared_bus.sv
// wb_shared_bus: N-master / M-slave Wishbone classic shared bus.
// One transaction at a time, round-robin grant, slave decoded from the top
// DECW address bits. Unmapped addresses end with a registered error pulse.
// Optional feature: define WB_SHARED_BUS_TIMEOUT_EN to terminate a beat with
// an error after TMO cycles of unanswered strobe.
module wb_shared_bus #(
  parameter int NM   = 4,
  parameter int NS   = 4,
  parameter int AW   = 36,
  parameter int DW   = 32,
  parameter int DECW = 4,
  parameter int TMO  = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_shared_bus_if.slave  m,
  wb_shared_bus_if.master s
);
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t          state;
  logic [GW-1:0]   g;
  logic [GW-1:0]   rr;
  logic [GW-1:0]   nxt_g;
  logic [GW-1:0]   cand;
  logic            found;
  logic            err_q;
  logic            tmo_q;
  logic            tmo_hit;

  logic            active;
  logic            g_cyc;
  logic            g_stb;
  logic            g_we;
  logic [AW-1:0]   g_adr;
  logic [DW/8-1:0] g_sel;
  logic [DW-1:0]   g_dat;
  logic [DECW-1:0] slv;
  logic            mapped;
  logic [NS-1:0]   sel_one;
  logic            slv_ack;
  logic            slv_err;
  logic [DW-1:0]   sel_dat;
  logic            g_ack;
  logic            g_err;

  // Reset forces every output low even before the state register clears.
  assign active = (state == ST_OWN) && !rst_i;

  // Granted master's request fields.
  assign g_cyc = |(m.m_cyc_i & (NM'(1) << g));
  assign g_stb = |(m.m_stb_i & (NM'(1) << g));
  assign g_we  = |(m.m_we_i  & (NM'(1) << g));
  assign g_adr = AW'(m.m_adr_i >> (int'(g) * AW));
  assign g_sel = (DW/8)'(m.m_sel_i >> (int'(g) * (DW/8)));
  assign g_dat = DW'(m.m_dat_i >> (int'(g) * DW));

  // Slave decode; indices at or beyond NS select nothing.
  assign slv     = g_adr[AW-1 -: DECW];
  assign mapped  = (int'(slv) < NS);
  assign sel_one = mapped ? (NS'(1) << slv) : '0;
  assign slv_ack = |(s.s_ack_i & sel_one);
  assign slv_err = |(s.s_err_i & sel_one);
  assign sel_dat = mapped ? DW'(s.s_dat_i >> (int'(slv) * DW)) : '0;

  // Terminations seen by the granted master. A timeout cycle blanks the
  // slave strobe, so nothing from the slave is forwarded during it.
  assign g_ack = active && !tmo_q && g_stb && slv_ack;
  assign g_err = active && (err_q || (!tmo_q && g_stb && slv_err));

  assign s.s_cyc_o = (active && !tmo_q && g_cyc) ? sel_one : '0;
  assign s.s_stb_o = (active && !tmo_q && g_stb) ? sel_one : '0;
  assign s.s_we_o  = active && g_we;
  assign s.s_adr_o = active ? g_adr : '0;
  assign s.s_sel_o = active ? g_sel : '0;
  assign s.s_dat_o = active ? g_dat : '0;

  assign m.m_dat_o = active ? sel_dat : '0;
  assign m.m_ack_o = g_ack ? (NM'(1) << g) : '0;
  assign m.m_err_o = g_err ? (NM'(1) << g) : '0;

  // Round-robin pick: first requester strictly after the last owner.
  always_comb begin
    nxt_g = rr;
    cand  = rr;
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      cand = GW'((int'(rr) + k) % NM);
      if (!found && m.m_cyc_i[cand]) begin
        nxt_g = cand;
        found = 1'b1;
      end
    end
  end

  // Ownership FSM plus the registered unmapped/timeout error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      rr    <= GW'(NM - 1);
      g     <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          err_q <= 1'b0;
          if (|m.m_cyc_i) begin
            g     <= nxt_g;
            rr    <= nxt_g;
            state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!g_cyc) begin
            err_q <= 1'b0;
            state <= ST_IDLE;
          end else begin
            // A held strobe after an error counts as a fresh beat.
            err_q <= (g_stb && !mapped && !err_q) || tmo_hit;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // A slave ack on the expiry cycle takes priority over the timeout.
  assign tmo_hit = active && g_cyc && g_stb && !g_ack && !g_err &&
                   (tmo_cnt == 16'(TMO - 1));

  // Count unanswered strobe cycles of the current beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (!active || !g_cyc || !g_stb || g_ack || g_err)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_q   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus: table of directed cycles, hand-written
// arbitration/lock sequences, and random traffic against a reference model.
module tb_wb_shared_bus;
  localparam int NM = 4, NS = 4, AW = 36, DW = 32, DECW = 4, TMO = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  wb_shared_bus_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus ();

  wb_shared_bus #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .DECW(DECW), .TMO(TMO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .m     (bus),
    .s     (bus)
  );

  // Stimulus
  logic [3:0]  cyc, stb, we, sack, serr;
  logic [35:0] adr [4];
  logic [3:0]  sel [4];
  logic [31:0] wdat [4];
  logic [31:0] sdat [4];

  assign bus.m_cyc_i = cyc;
  assign bus.m_stb_i = stb;
  assign bus.m_we_i  = we;
  assign bus.m_adr_i = {adr[3], adr[2], adr[1], adr[0]};
  assign bus.m_sel_i = {sel[3], sel[2], sel[1], sel[0]};
  assign bus.m_dat_i = {wdat[3], wdat[2], wdat[1], wdat[0]};
  assign bus.s_dat_i = {sdat[3], sdat[2], sdat[1], sdat[0]};
  assign bus.s_ack_i = sack;
  assign bus.s_err_i = serr;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: who owns the bus, last winner, pending error pulse.
  int mo_owner = -1;
  int mo_rr    = NM - 1;
  bit mo_pend  = 1'b0;
  bit mo_force = 1'b0;
  int mo_cnt   = 0;

  logic [3:0]  e_scyc, e_sstb, e_mack, e_merr, e_sel;
  logic [31:0] e_mdat, e_wdat;
  logic        e_we;
  logic [35:0] e_adr;

  task automatic model_eval();
    int o;
    int sl;
    e_scyc = '0; e_sstb = '0; e_mack = '0; e_merr = '0;
    e_mdat = '0; e_we = 1'b0; e_adr = '0; e_sel = '0; e_wdat = '0;
    if (!rst_i && mo_owner >= 0) begin
      o  = mo_owner;
      sl = int'(adr[o][35:32]);
      e_we = we[o]; e_adr = adr[o]; e_sel = sel[o]; e_wdat = wdat[o];
      if (sl < NS) begin
        e_mdat = sdat[sl];
        if (!mo_force) begin
          if (cyc[o]) e_scyc = 4'(1 << sl);
          if (stb[o]) e_sstb = 4'(1 << sl);
          if (stb[o] && sack[sl]) e_mack = 4'(1 << o);
          if (stb[o] && serr[sl]) e_merr = 4'(1 << o);
        end
      end
      if (mo_pend) e_merr = 4'(1 << o);
    end
  endtask

  task automatic model_step();
    int o;
    bit hit;
    if (rst_i) begin
      mo_owner = -1; mo_rr = NM - 1; mo_pend = 0; mo_force = 0; mo_cnt = 0;
    end else if (mo_owner < 0) begin
      mo_pend = 0; mo_force = 0; mo_cnt = 0;
      for (int k = 1; k <= NM; k++) begin
        if (mo_owner < 0 && cyc[(mo_rr + k) % NM]) mo_owner = (mo_rr + k) % NM;
      end
      if (mo_owner >= 0) mo_rr = mo_owner;
    end else if (!cyc[mo_owner]) begin
      mo_owner = -1; mo_pend = 0; mo_force = 0; mo_cnt = 0;
    end else begin
      o = mo_owner;
      model_eval();
      hit = 0;
`ifdef WB_SHARED_BUS_TIMEOUT_EN
      if (!stb[o] || e_mack != 0 || e_merr != 0) mo_cnt = 0;
      else begin
        if (mo_cnt == TMO - 1) hit = 1;
        mo_cnt++;
      end
`endif
      mo_pend  = (int'(adr[o][35:32]) >= NS && stb[o] && !mo_pend) || hit;
      mo_force = hit;
    end
  endtask

  task automatic check_model(input string tag);
    model_eval();
    chk({tag, ".s_cyc"}, bus.s_cyc_o, e_scyc);
    chk({tag, ".s_stb"}, bus.s_stb_o, e_sstb);
    chk({tag, ".m_ack"}, bus.m_ack_o, e_mack);
    chk({tag, ".m_err"}, bus.m_err_o, e_merr);
    chk({tag, ".m_dat"}, bus.m_dat_o, e_mdat);
    chk({tag, ".s_we"},  bus.s_we_o,  e_we);
    chk({tag, ".s_adr"}, bus.s_adr_o, e_adr);
    chk({tag, ".s_sel"}, bus.s_sel_o, e_sel);
    chk({tag, ".s_dat"}, bus.s_dat_o, e_wdat);
  endtask

  // Advance one clock: DUT and model see the same inputs at the edge.
  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; sack = '0; serr = '0;
    for (int k = 0; k < 4; k++) begin
      adr[k] = '0; sel[k] = 4'hF; wdat[k] = '0;
    end
    sdat[0] = 32'h0; sdat[1] = 32'h1111_1111;
    sdat[2] = 32'hDEAD_BEEF; sdat[3] = 32'h3333_3333;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  cyc, stb, sack, serr;
    logic [35:0] adr;
    logic [3:0]  e_scyc, e_sstb, e_mack, e_merr;
    logic [31:0] e_mdat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [3:0] c, input logic [3:0] s_,
                     input logic [3:0] ak, input logic [3:0] er, input logic [35:0] a,
                     input logic [3:0] ec, input logic [3:0] es, input logic [3:0] ea,
                     input logic [3:0] ee, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s_; v.sack = ak; v.serr = er; v.adr = a;
    v.e_scyc = ec; v.e_sstb = es; v.e_mack = ea; v.e_merr = ee; v.e_mdat = ed;
    tbl.push_back(v);
  endtask

  logic [3:0] a_seen, drop;
  int acks, last, idx;
  logic [3:0] exp_ack [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    @(negedge clk_i);

    // Master-0 cycles: rst,cyc,stb,sack,serr,adr | s_cyc,s_stb,m_ack,m_err,m_dat
    add(1, 0, 0, 0, 0, 36'h0_0000_0010, 0, 0, 0, 0, 32'h0);
    add(1, 1, 1, 0, 0, 36'h0_0000_0010, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h0_0000_0010, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h0_0000_0010, 1, 1, 0, 0, 32'h0);
    add(0, 1, 1, 1, 0, 36'h0_0000_0010, 1, 1, 1, 0, 32'h0);
    add(0, 0, 0, 0, 0, 36'h0_0000_0010, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h2_0000_0004, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h2_0000_0004, 4, 4, 0, 0, 32'hDEAD_BEEF);
    add(0, 0, 1, 4, 0, 36'h2_0000_0004, 0, 4, 1, 0, 32'hDEAD_BEEF);
    add(0, 0, 0, 0, 0, 36'h2_0000_0004, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h5_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h5_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h5_0000_0000, 0, 0, 0, 1, 32'h0);
    add(0, 1, 0, 0, 0, 36'h5_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h5_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 0, 0, 0, 36'h5_0000_0000, 0, 0, 0, 1, 32'h0);
    add(0, 0, 0, 0, 0, 36'h5_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h1_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 2, 36'h1_0000_0000, 2, 2, 0, 1, 32'h1111_1111);
    add(0, 0, 0, 0, 0, 36'h1_0000_0000, 0, 0, 0, 0, 32'h1111_1111);
    add(0, 1, 1, 0, 0, 36'h3_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 36'h3_0000_0000, 8, 8, 0, 0, 32'h3333_3333);
    add(1, 1, 1, 8, 0, 36'h3_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 8, 0, 36'h3_0000_0000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 8, 0, 36'h3_0000_0000, 8, 8, 1, 0, 32'h3333_3333);
    add(0, 0, 0, 0, 0, 36'h3_0000_0000, 0, 0, 0, 0, 32'h3333_3333);

    foreach (tbl[i]) begin
      rst_i = tbl[i].rst; cyc = tbl[i].cyc; stb = tbl[i].stb;
      sack = tbl[i].sack; serr = tbl[i].serr; adr[0] = tbl[i].adr;
      #1;
      chk($sformatf("row%0d.s_cyc", i), bus.s_cyc_o, tbl[i].e_scyc);
      chk($sformatf("row%0d.s_stb", i), bus.s_stb_o, tbl[i].e_sstb);
      chk($sformatf("row%0d.m_ack", i), bus.m_ack_o, tbl[i].e_mack);
      chk($sformatf("row%0d.m_err", i), bus.m_err_o, tbl[i].e_merr);
      chk($sformatf("row%0d.m_dat", i), bus.m_dat_o, tbl[i].e_mdat);
      tick();
    end

    // Fairness: all masters request, each drops cyc for one cycle after its ack.
    do_reset();
    sack = 4'b0001;
    drop = '0; acks = 0; last = -1;
    for (int c = 0; c < 40 && acks < 5; c++) begin
      cyc = ~drop; stb = ~drop;
      #1;
      check_model($sformatf("rr.c%0d", c));
      a_seen = bus.m_ack_o;
      if (a_seen != 0) begin
        idx = 0;
        for (int k = 3; k >= 0; k--) if (a_seen[k]) idx = k;
        chk($sformatf("rr_order%0d", acks), idx, acks % NM);
        if (acks > 0) chk($sformatf("rr_gap%0d", acks), c - last, 3);
        last = c;
        acks++;
      end
      drop = a_seen;
      tick();
    end
    if (acks < 5) begin
      n_vec++; n_bad++;
      $display("FAIL rr_count: got %0d grants, want 5", acks);
    end

    // Lock: master 1 keeps cyc for three beats while master 2 waits.
    do_reset();
    adr[1] = 36'h0_0000_0100; adr[2] = 36'h1_0000_0200;
    sack = 4'b0011;
    exp_ack = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
    for (int c = 0; c < 7; c++) begin
      cyc = (c >= 4) ? 4'b0100 : 4'b0110;
      stb = cyc;
      #1;
      check_model($sformatf("lock.c%0d", c));
      chk($sformatf("lock_ack%0d", c), bus.m_ack_o, exp_ack[c]);
      tick();
    end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
    // Hung slave: err after TMO strobe cycles, then reset mid-beat.
    do_reset();
    adr[0] = 36'h1_0000_0000;
    cyc = 4'b0001; stb = 4'b0001;
    for (int c = 0; c < 11; c++) begin
      #1;
      check_model($sformatf("tmo.c%0d", c));
      chk($sformatf("tmo_err%0d", c), bus.m_err_o, (c == TMO + 1) ? 4'b0001 : 4'b0000);
      chk($sformatf("tmo_stb%0d", c), bus.s_stb_o,
          (c == 0 || c == TMO + 1) ? 4'b0000 : 4'b0010);
      tick();
    end
    rst_i = 1'b1; sack = 4'b0010;
    #1;
    chk("tmo_rst_ack", bus.m_ack_o, 4'b0000);
    chk("tmo_rst_stb", bus.s_stb_o, 4'b0000);
    tick();
    rst_i = 1'b0;
    #1;
    check_model("tmo.after_rst");
    chk("tmo_idle_ack", bus.m_ack_o, 4'b0000);
    tick();
    #1;
    chk("tmo_regrant_ack", bus.m_ack_o, 4'b0001);
    tick();
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) cyc[k] = ~cyc[k];
        stb[k] = $urandom_range(0, 1) == 1;
        we[k]  = $urandom_range(0, 1) == 1;
        adr[k] = {4'($urandom_range(0, 5)), $urandom()};
        sel[k] = 4'($urandom());
        wdat[k] = $urandom();
        sdat[k] = $urandom();
      end
      sack = 4'($urandom()) & 4'($urandom());
      serr = (($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'h0);
      #1;
      check_model($sformatf("rnd.c%0d", c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
